axil_master_adaptor: RTL and testbench



---
 rtl/axil_master_adaptor.sv | 208 ++++++++++++++++++++
 tb/tb_axil_master_adaptor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_master_adaptor.sv
// axil_master_adaptor: single-outstanding AXI4-Lite initiator.
// It turns a valid/ready command/response pair into one AXI4-Lite read or
// write transfer. Sub-word writes get lane strobes and replicated data.
// Sub-word reads are shifted down to bit 0 and zero-extended.
module axil_master_adaptor #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  localparam int strb_w = axil_data_width_p / 8,
  localparam int off_w  = $clog2(strb_w),
  localparam int size_w = $clog2(off_w + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  // PL-side command
  input  logic                         cmd_v_i,
  output logic                         cmd_ready_and_o,
  input  logic [axil_addr_width_p-1:0] cmd_addr_i,
  input  logic                         cmd_wr_en_i,
  input  logic [size_w-1:0]            cmd_data_size_i,
  input  logic [axil_data_width_p-1:0] cmd_wdata_i,
  // PL-side response
  output logic                         resp_v_o,
  input  logic                         resp_ready_and_i,
  output logic [axil_data_width_p-1:0] resp_rdata_o,
  output logic                         resp_err_o,
  // AXI4-Lite write address
  output logic [axil_addr_width_p-1:0] m_axil_awaddr_o,
  output logic [2:0]                   m_axil_awprot_o,
  output logic                         m_axil_awvalid_o,
  input  logic                         m_axil_awready_i,
  // AXI4-Lite write data
  output logic [axil_data_width_p-1:0] m_axil_wdata_o,
  output logic [strb_w-1:0]            m_axil_wstrb_o,
  output logic                         m_axil_wvalid_o,
  input  logic                         m_axil_wready_i,
  // AXI4-Lite write response
  input  logic [1:0]                   m_axil_bresp_i,
  input  logic                         m_axil_bvalid_i,
  output logic                         m_axil_bready_o,
  // AXI4-Lite read address
  output logic [axil_addr_width_p-1:0] m_axil_araddr_o,
  output logic [2:0]                   m_axil_arprot_o,
  output logic                         m_axil_arvalid_o,
  input  logic                         m_axil_arready_i,
  // AXI4-Lite read data
  input  logic [axil_data_width_p-1:0] m_axil_rdata_i,
  input  logic [1:0]                   m_axil_rresp_i,
  input  logic                         m_axil_rvalid_i,
  output logic                         m_axil_rready_o
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_e;

  state_e                       state_q;
  logic [axil_addr_width_p-1:0] addr_q;
  logic [size_w-1:0]            size_q;
  logic [strb_w-1:0]            wstrb_q;
  logic [axil_data_width_p-1:0] wdata_q;
  logic                         aw_done_q, w_done_q;
  logic                         cmd_ready_q, awvalid_q, wvalid_q, bready_q;
  logic                         arvalid_q, rready_q, resp_v_q, resp_err_q;
  logic [axil_data_width_p-1:0] resp_rdata_q;

  // Lane masks: bit b set when address bit b lies inside the access size.
  logic [off_w-1:0]             cmd_mask, cmd_off, rd_mask, rd_off;
  logic [strb_w-1:0]            cmd_wstrb;
  logic [axil_data_width_p-1:0] cmd_wdata_rep, rdata_aligned;

  // Size-dependent low-bit masks and aligned-down lane offsets.
  always_comb begin
    cmd_mask = '0;
    rd_mask  = '0;
    for (int b = 0; b < off_w; b++) begin
      cmd_mask[b] = (b < int'(cmd_data_size_i));
      rd_mask[b]  = (b < int'(size_q));
    end
    cmd_off = cmd_addr_i[off_w-1:0] & ~cmd_mask;
    rd_off  = addr_q[off_w-1:0] & ~rd_mask;
  end

  // Per-lane strobe, write replication and read alignment.
  for (genvar gi = 0; gi < strb_w; gi++) begin : g_lane
    localparam logic [off_w-1:0] lane_lp = off_w'(gi);
    // A lane is inside the aligned block when its upper bits match the offset.
    assign cmd_wstrb[gi] = ((lane_lp & ~cmd_mask) == cmd_off);
    // Each lane repeats the source byte at its position within the block.
    assign cmd_wdata_rep[8*gi +: 8] = cmd_wdata_i[{(lane_lp & cmd_mask), 3'b000} +: 8];
    // Output lane gi takes byte (offset + gi) when gi is within the size.
    assign rdata_aligned[8*gi +: 8] = ((lane_lp & ~rd_mask) == '0)
                                      ? m_axil_rdata_i[{(rd_off | lane_lp), 3'b000} +: 8]
                                      : 8'h00;
  end

  // Only the error bit of the AXI response codes is reported.
  logic unused_resp_bits;
  assign unused_resp_bits = m_axil_bresp_i[0] ^ m_axil_rresp_i[0];

  // Transaction FSM; every interface output is a register updated here.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      cmd_ready_q  <= 1'b1;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_v_q     <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_v_i) begin
            addr_q      <= cmd_addr_i;
            size_q      <= cmd_data_size_i;
            cmd_ready_q <= 1'b0;
            if (cmd_wr_en_i) begin
              wstrb_q   <= cmd_wstrb;
              wdata_q   <= cmd_wdata_rep;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_ADDR_DATA;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (awvalid_q && m_axil_awready_i) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (wvalid_q && m_axil_wready_i) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          // Both channels done, counting a handshake completing right now.
          if ((aw_done_q || m_axil_awready_i) && (w_done_q || m_axil_wready_i)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid_i) begin
            bready_q     <= 1'b0;
            resp_err_q   <= m_axil_bresp_i[1];
            resp_rdata_q <= '0;
            resp_v_q     <= 1'b1;
            state_q      <= RESP;
          end
        end
        RD_ADDR: begin
          if (m_axil_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axil_rvalid_i) begin
            rready_q     <= 1'b0;
            resp_err_q   <= m_axil_rresp_i[1];
            resp_rdata_q <= rdata_aligned;
            resp_v_q     <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_and_i) begin
            resp_v_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_and_o  = cmd_ready_q;
  assign resp_v_o         = resp_v_q;
  assign resp_rdata_o     = resp_rdata_q;
  assign resp_err_o       = resp_err_q;
  assign m_axil_awaddr_o  = addr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wstrb_o   = wstrb_q;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_bready_o  = bready_q;
  assign m_axil_araddr_o  = addr_q;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = arvalid_q;
  assign m_axil_rready_o  = rready_q;

endmodule

// File: tb/tb_axil_master_adaptor.sv
// Directed bench for axil_master_adaptor (32-bit data, 32-bit address).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axil_master_adaptor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_v, cmd_ready, cmd_wr_en;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        resp_v, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axil_master_adaptor #(.axil_data_width_p(32), .axil_addr_width_p(32)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .cmd_v_i(cmd_v), .cmd_ready_and_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_wr_en_i(cmd_wr_en), .cmd_data_size_i(cmd_size), .cmd_wdata_i(cmd_wdata),
    .resp_v_o(resp_v), .resp_ready_and_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid),
    .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Snapshot of all handshake outputs: {cmd_ready, awvalid, wvalid, bready, arvalid, rready, resp_v}
  function automatic logic [6:0] hs();
    return {cmd_ready, awvalid, wvalid, bready, arvalid, rready, resp_v};
  endfunction

  task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    cmd_v = 1'b1; cmd_wr_en = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = d;
  endtask

  // Write against a slave that is always ready; response accepted at once.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
    @(negedge clk);
    issue(1'b1, a, sz, d);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; resp_ready = 1'b0;
    @(negedge clk);                                   // cycle 1
    cmd_v = 1'b0;
    check({tag, " c1 handshakes"}, hs(), 7'b0110000);
    check({tag, " awaddr"}, awaddr, a);
    check({tag, " wstrb"}, wstrb, exp_strb);
    check({tag, " wdata"}, wdata, exp_wdata);
    @(negedge clk);                                   // cycle 2
    check({tag, " c2 handshakes"}, hs(), 7'b0001000);
    @(negedge clk);                                   // cycle 3
    check({tag, " c3 handshakes"}, hs(), 7'b0000001);
    check({tag, " rdata"}, resp_rdata, 32'h0);
    check({tag, " err"}, resp_err, 1'b0);
    bvalid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " idle"}, hs(), 7'b1000000);
  endtask

  // Read against a slave that is always ready.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] slave_data, input logic [31:0] exp_data);
    @(negedge clk);
    issue(1'b0, a, sz, 32'h0);
    arready = 1'b1; rvalid = 1'b1; rdata = slave_data; rresp = 2'b00; resp_ready = 1'b0;
    @(negedge clk);                                   // cycle 1
    cmd_v = 1'b0;
    check({tag, " c1 handshakes"}, hs(), 7'b0000100);
    check({tag, " araddr"}, araddr, a);
    @(negedge clk);                                   // cycle 2
    check({tag, " c2 handshakes"}, hs(), 7'b0000010);
    @(negedge clk);                                   // cycle 3
    check({tag, " c3 handshakes"}, hs(), 7'b0000001);
    check({tag, " rdata"}, resp_rdata, exp_data);
    check({tag, " err"}, resp_err, 1'b0);
    rvalid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " idle"}, hs(), 7'b1000000);
  endtask

  initial begin
    rst_n = 1'b0; cmd_v = 1'b0; cmd_wr_en = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    resp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset handshakes", hs(), 7'b1000000);
    check("reset rdata", resp_rdata, 32'h0);
    check("reset err", resp_err, 1'b0);
    check("reset awaddr", awaddr, 32'h0);
    check("reset wdata", wdata, 32'h0);
    check("reset wstrb", wstrb, 4'h0);
    check("prot", {awprot, arprot}, 6'b0);
    rst_n = 1'b1;

    // Directed writes and reads
    do_write("wr full", 32'h40, 2'd2, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    do_write("wr byte", 32'h43, 2'd0, 32'h0000005A, 4'h8, 32'h5A5A5A5A);
    do_write("wr half", 32'h02, 2'd1, 32'h00001234, 4'hC, 32'h12341234);
    do_write("wr byte0", 32'h44, 2'd0, 32'hFFFFFF7E, 4'h1, 32'h7E7E7E7E);
    do_read("rd half", 32'h102, 2'd1, 32'hCAFEF00D, 32'h0000CAFE);
    do_read("rd byte", 32'h101, 2'd0, 32'hCAFEF00D, 32'h000000F0);
    do_read("rd byte3", 32'h103, 2'd0, 32'hCAFEF00D, 32'h000000CA);
    do_read("rd half unal", 32'h101, 2'd1, 32'hCAFEF00D, 32'h0000F00D);
    do_read("rd full", 32'h100, 2'd2, 32'hCAFEF00D, 32'hCAFEF00D);

    // Skewed write: wready 3 cycles before awready, early bvalid held off
    @(negedge clk);
    issue(1'b1, 32'h20, 2'd2, 32'h01020304);
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    @(negedge clk);
    cmd_v = 1'b0;
    check("skew both valid", hs(), 7'b0110000);
    bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("skew aw waiting", hs(), 7'b0100000);
      check("skew awaddr stable", awaddr, 32'h20);
    end
    awready = 1'b1;
    @(negedge clk);
    check("skew bready", hs(), 7'b0001000);
    @(negedge clk);
    check("skew resp", hs(), 7'b0000001);
    bvalid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("skew idle", hs(), 7'b1000000);

    // Error response with response back-pressure; no same-cycle command bypass
    @(negedge clk);
    issue(1'b1, 32'h10, 2'd2, 32'h55AA55AA);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    @(negedge clk);
    cmd_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    issue(1'b0, 32'h200, 2'd2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("err resp held", hs(), 7'b0000001);
      check("err flag", resp_err, 1'b1);
      check("err rdata", resp_rdata, 32'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("no bypass", hs(), 7'b1000000);
    cmd_v = 1'b0;
    @(negedge clk);
    check("stays idle", hs(), 7'b1000000);

    // Reset while in RD_DATA with rvalid pending
    issue(1'b0, 32'h104, 2'd2, 32'h0);
    arready = 1'b1; rvalid = 1'b0;
    @(negedge clk);
    cmd_v = 1'b0;
    @(negedge clk);
    check("rst rd_data", hs(), 7'b0000010);
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'h11223344;
    #1 rst_n = 1'b0;
    #1;
    check("rst immediate", hs(), 7'b1000000);
    check("rst rdata", resp_rdata, 32'h0);
    check("rst err", resp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b0; rresp = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check("rst no resp", hs(), 7'b1000000);
    end
    do_read("post rst rd", 32'h104, 2'd2, 32'h55667788, 32'h55667788);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
